ps2_key_decoder: RTL

Converts the PS/2 scan-code byte stream from the keyboard receiver into the synth's note and control signals: `note`, `note_in`, and one-cycle octave and amplitude increment/decrement pulses. It sits between the PS/2 byte receiver and the top-level settings registers and `ALUcontroller`. It handles set-2 make/break framing (`F0`) and extended prefixes (`E0`). It gives last-key-pressed priority to notes and suppresses typematic repeats on control keys.

---
 rtl/ps2_key_decoder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Purpose:
//   Turns the PS/2 set-2 scan-code byte stream into synth controls.
//   - Note keys drive a 4-bit semitone index and a "note held" flag.
//     The most recently pressed note key always takes over.
//   - Four control keys (X, Z, '=', '-') each produce a one-cycle pulse.
//     Typematic repeats of a key that is still held produce no pulse.
//   - F0 (break) and E0 (extended) prefixes are framed by a small FSM.
//     Extended keys never affect any output.
//   - Keyboard error/BAT codes and abandoned prefixes raise kbd_error.
//
// Ports:
//   clk                 in  1  system clock
//   reset               in  1  synchronous, active-low reset
//   rx_byte             in  8  received scan-code byte (valid with rx_valid)
//   rx_valid            in  1  one-cycle strobe per received byte
//   note                out 4  semitone index 0..11 of active/last note key
//   note_in             out 1  high while the key driving note is held
//   octave_plus_plus    out 1  one-cycle pulse, X pressed
//   octave_minus_minus  out 1  one-cycle pulse, Z pressed
//   amp_plus_plus       out 1  one-cycle pulse, '=' pressed
//   amp_minus_minus     out 1  one-cycle pulse, '-' pressed
//   kbd_error           out 1  one-cycle pulse on error/BAT code or timeout
//
// Parameters:
//   TIMEOUT_CYCLES      cycles a prefix state waits for its follow-up byte
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [3:0] note,
  output logic       note_in,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic       amp_plus_plus,
  output logic       amp_minus_minus,
  output logic       kbd_error
);

  // A counter of $clog2(TIMEOUT_CYCLES) bits is enough because it only ever
  // has to reach TIMEOUT_CYCLES-1. Keep at least one bit for tiny values.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] C_BREAK = 8'hF0;
  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BAT   = 8'hAA;
  localparam logic [7:0] C_ERR0  = 8'hFC;
  localparam logic [7:0] C_ERR1  = 8'hFF;

  // Control key slots, shared by the held mask and the pulse vector.
  localparam logic [1:0] K_OCT_P = 2'd0;
  localparam logic [1:0] K_OCT_M = 2'd1;
  localparam logic [1:0] K_AMP_P = 2'd2;
  localparam logic [1:0] K_AMP_M = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_note;
  logic [3:0]      w_note_next;
  logic            r_note_in;
  logic            w_note_in_next;
  logic [3:0]      r_held;
  logic [3:0]      w_held_next;
  logic [3:0]      r_pulse;
  logic [3:0]      w_pulse_next;
  logic            r_err;
  logic            w_err_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;

  // -------------------------------------------------------------------------
  // Scan-code decode (pure combinational lookup of the current byte)
  // -------------------------------------------------------------------------
  logic       w_note_hit;
  logic [3:0] w_note_val;
  logic       w_ctl_hit;
  logic [1:0] w_ctl_idx;
  logic       w_is_err_code;

  always_comb begin
    w_note_hit = 1'b1;
    w_note_val = 4'd0;
    case (rx_byte)
      8'h1C:   w_note_val = 4'd0;
      8'h1D:   w_note_val = 4'd1;
      8'h1B:   w_note_val = 4'd2;
      8'h24:   w_note_val = 4'd3;
      8'h23:   w_note_val = 4'd4;
      8'h2B:   w_note_val = 4'd5;
      8'h2C:   w_note_val = 4'd6;
      8'h34:   w_note_val = 4'd7;
      8'h35:   w_note_val = 4'd8;
      8'h33:   w_note_val = 4'd9;
      8'h3C:   w_note_val = 4'd10;
      8'h3B:   w_note_val = 4'd11;
      default: w_note_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_ctl_hit = 1'b1;
    w_ctl_idx = K_OCT_P;
    case (rx_byte)
      8'h22:   w_ctl_idx = K_OCT_P;  // X
      8'h1A:   w_ctl_idx = K_OCT_M;  // Z
      8'h55:   w_ctl_idx = K_AMP_P;  // =
      8'h4E:   w_ctl_idx = K_AMP_M;  // -
      default: w_ctl_hit = 1'b0;
    endcase
  end

  assign w_is_err_code = (rx_byte == C_BAT) || (rx_byte == C_ERR0) ||
                         (rx_byte == C_ERR1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_note    <= 4'd0;
      r_note_in <= 1'b0;
      r_held    <= 4'd0;
      r_pulse   <= 4'd0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_note    <= w_note_next;
      r_note_in <= w_note_in_next;
      r_held    <= w_held_next;
      r_pulse   <= w_pulse_next;
      r_err     <= w_err_next;
      r_cnt     <= w_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_note_next    = r_note;
    w_note_in_next = r_note_in;
    w_held_next    = r_held;
    w_pulse_next   = 4'd0;
    w_err_next     = 1'b0;
    w_cnt_next     = r_cnt;

    if (rx_valid) begin
      // Any byte restarts the prefix timeout; a byte arriving in the same
      // cycle as the timeout wins and is processed normally.
      w_cnt_next = '0;
      case (r_state)
        S_IDLE: begin
          if (rx_byte == C_BREAK) begin
            w_state_next = S_BRK;
          end else if (rx_byte == C_EXT) begin
            w_state_next = S_EXT;
          end else if (w_is_err_code) begin
            // Keyboard reset/error: key-up events may have been lost, so
            // forget everything we believe is held.
            w_note_in_next = 1'b0;
            w_held_next    = 4'd0;
            w_err_next     = 1'b1;
          end else if (w_note_hit) begin
            w_note_next    = w_note_val;
            w_note_in_next = 1'b1;
          end else if (w_ctl_hit) begin
            // Only the first make of a held key pulses; repeats are absorbed.
            w_pulse_next[w_ctl_idx] = ~r_held[w_ctl_idx];
            w_held_next[w_ctl_idx]  = 1'b1;
          end
        end
        S_BRK: begin
          w_state_next = S_IDLE;
          if (w_note_hit) begin
            // Releasing a key that was overridden must not silence the
            // newer note.
            if (w_note_val == r_note) begin
              w_note_in_next = 1'b0;
            end
          end else if (w_ctl_hit) begin
            w_held_next[w_ctl_idx] = 1'b0;
          end
        end
        S_EXT: begin
          w_state_next = (rx_byte == C_BREAK) ? S_EXT_BRK : S_IDLE;
        end
        S_EXT_BRK: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end else if (r_state != S_IDLE) begin
      // Waiting for the byte after a prefix. The >= compare keeps the
      // counter saturating rather than wrapping.
      if (r_cnt >= TO_LAST) begin
        w_state_next = S_IDLE;
        w_err_next   = 1'b1;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // -------------------------------------------------------------------------
  assign note               = r_note;
  assign note_in            = r_note_in;
  assign octave_plus_plus   = r_pulse[K_OCT_P];
  assign octave_minus_minus = r_pulse[K_OCT_M];
  assign amp_plus_plus      = r_pulse[K_AMP_P];
  assign amp_minus_minus    = r_pulse[K_AMP_M];
  assign kbd_error          = r_err;

endmodule
